// File: rtl/tail_light_seq.sv
// Sequential tail-light controller: LAMPS-wide thermometer turn signals, hazard flash, tick prescaler.
// Optional brake overlay compiled in with `define TL_BRAKE_EN (adds port brk, applied every clk).
module tail_light_seq #(
  parameter int LAMPS = 3,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lt,
  input  logic             rt,
  input  logic             haz,
`ifdef TL_BRAKE_EN
  input  logic             brk,
`endif
  output logic [LAMPS-1:0] li,
  output logic [LAMPS-1:0] ri,
  output logic             busy
);

  localparam int SW = $clog2(LAMPS + 1);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0]    LAST = SW'(LAMPS);
  localparam logic [CW-1:0]    CMAX = CW'(DIV - 1);
  localparam logic [LAMPS-1:0] ALL  = {LAMPS{1'b1}};

  typedef enum logic [2:0] {IDLE, LEFT, RIGHT, HAZ_ON, HAZ_OFF} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SW-1:0]    r_step;
  logic [SW-1:0]    w_step_nxt;
  logic [CW-1:0]    r_cnt;
  logic [LAMPS-1:0] r_li;
  logic [LAMPS-1:0] r_ri;
  logic             r_busy;
  logic             w_tick;
  logic             w_hz;
  logic             w_brk;
  logic [LAMPS-1:0] w_pat;

`ifdef TL_BRAKE_EN
  assign w_brk = brk;
`else
  assign w_brk = 1'b0;
`endif

  assign w_tick = (r_cnt == CMAX);
  assign w_hz   = haz | (lt & rt);
  // Thermometer of the upcoming step: (1<<step)-1, all ones at step==LAMPS.
  assign w_pat  = ~(ALL << w_step_nxt);

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
          if (w_hz) begin
            w_state_nxt = HAZ_ON;
          end else if (lt) begin
            w_state_nxt = LEFT;
            w_step_nxt  = SW'(1);
          end else if (rt) begin
            w_state_nxt = RIGHT;
            w_step_nxt  = SW'(1);
          end
        end
        LEFT, RIGHT: begin
          if (w_hz) begin
            w_state_nxt = HAZ_ON;
            w_step_nxt  = '0;
          end else if (r_step == LAST) begin
            w_state_nxt = IDLE;
            w_step_nxt  = '0;
          end else begin
            w_step_nxt  = r_step + 1'b1;
          end
        end
        HAZ_ON:  w_state_nxt = w_hz ? HAZ_OFF : IDLE;
        HAZ_OFF: w_state_nxt = w_hz ? HAZ_ON : IDLE;
        default: begin
          w_state_nxt = IDLE;
          w_step_nxt  = '0;
        end
      endcase
    end
  end

  // Lamps are derived from the next state every clk so the brake overlay lands one edge after brk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_step  <= '0;
      r_cnt   <= '0;
      r_li    <= '0;
      r_ri    <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
      r_state <= w_state_nxt;
      r_step  <= w_step_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      case (w_state_nxt)
        LEFT: begin
          r_li <= w_pat;
          r_ri <= w_brk ? ALL : '0;
        end
        RIGHT: begin
          r_li <= w_brk ? ALL : '0;
          r_ri <= w_pat;
        end
        HAZ_ON: begin
          r_li <= ALL;
          r_ri <= ALL;
        end
        HAZ_OFF: begin
          r_li <= '0;
          r_ri <= '0;
        end
        default: begin
          r_li <= w_brk ? ALL : '0;
          r_ri <= w_brk ? ALL : '0;
        end
      endcase
    end
  end

  assign li   = r_li;
  assign ri   = r_ri;
  assign busy = r_busy;

endmodule

// File: tb/tb_tail_light_seq.sv
// Directed bench for tail_light_seq: LAMPS=3/DIV=4 main instance plus a LAMPS=5/DIV=1 instance.
// Expected lamp frames are queued before each step and popped against the DUT after the edge.
module tb_tail_light_seq;

  logic       clk;
  logic       rst_a, lt_a, rt_a, haz_a;
  logic [2:0] li_a, ri_a;
  logic       busy_a;
  logic       rst5, lt5, rt5, haz5;
  logic [4:0] li5, ri5;
  logic       busy5;
`ifdef TL_BRAKE_EN
  logic       brk_a, brk5;
`endif

  int total = 0;
  int bad   = 0;
  logic [10:0] sb[$];

  tail_light_seq #(.LAMPS(3), .DIV(4)) u_a (
    .clk(clk), .rst(rst_a), .lt(lt_a), .rt(rt_a), .haz(haz_a),
`ifdef TL_BRAKE_EN
    .brk(brk_a),
`endif
    .li(li_a), .ri(ri_a), .busy(busy_a)
  );

  tail_light_seq #(.LAMPS(5), .DIV(1)) u_5 (
    .clk(clk), .rst(rst5), .lt(lt5), .rt(rt5), .haz(haz5),
`ifdef TL_BRAKE_EN
    .brk(brk5),
`endif
    .li(li5), .ri(ri5), .busy(busy5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] l, input logic [4:0] r, input logic b);
    sb.push_back({l, r, b});
  endtask

  task automatic check_pop(input string tag, input logic [10:0] obs);
    logic [10:0] exp;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        bad++;
        $error("FAIL %s: observed={li,ri,busy}=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  task automatic check_a(input string tag);
    check_pop(tag, {2'b00, li_a, 2'b00, ri_a, busy_a});
  endtask

  // Expect a frame after n edges on the main instance.
  task automatic step_a(input int n, input logic [2:0] l, input logic [2:0] r,
                        input logic b, input string tag);
    push({2'b00, l}, {2'b00, r}, b);
    edges(n);
    check_a(tag);
  endtask

  task automatic tick_a(input logic [2:0] l, input logic [2:0] r, input logic b,
                        input string tag);
    step_a(4, l, r, b, tag);
  endtask

  logic [2:0] exp_pat [4];

  initial begin
    exp_pat[0] = 3'b001; exp_pat[1] = 3'b011; exp_pat[2] = 3'b111; exp_pat[3] = 3'b000;
    rst_a = 1'b1; lt_a = 1'b0; rt_a = 1'b0; haz_a = 1'b0;
    rst5  = 1'b1; lt5  = 1'b0; rt5  = 1'b0; haz5  = 1'b0;
`ifdef TL_BRAKE_EN
    brk_a = 1'b0; brk5 = 1'b0;
`endif
    #12;
    push(5'd0, 5'd0, 1'b0);
    check_a("reset_state");
    push(5'd0, 5'd0, 1'b0);
    check_pop("reset_state_l5", {li5, ri5, busy5});

    // lt held through reset release; first tick lands on the 4th edge
    lt_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    step_a(3, 3'b000, 3'b000, 1'b0, "pre_first_tick");
    step_a(1, 3'b001, 3'b000, 1'b1, "first_tick");
    for (int k = 2; k <= 12; k++)
      tick_a(exp_pat[(k - 1) % 4], 3'b000, (k % 4) != 0, $sformatf("lt_held_t%0d", k));
    tick_a(3'b001, 3'b000, 1'b1, "lt_t13");
    tick_a(3'b011, 3'b000, 1'b1, "lt_t14");

    // async reset mid-sequence while li=011
    #2;
    rst_a = 1'b1;
    #1;
    push(5'd0, 5'd0, 1'b0);
    check_a("async_reset");
    lt_a = 1'b0;
    rt_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    step_a(3, 3'b000, 3'b000, 1'b0, "rst_pre_tick");
    step_a(1, 3'b000, 3'b001, 1'b1, "rst_first_tick");

    // rt dropped at step 1: sequence still completes, then stays idle
    rt_a = 1'b0;
    tick_a(3'b000, 3'b011, 1'b1, "rt_drop_s2");
    tick_a(3'b000, 3'b111, 1'b1, "rt_drop_s3");
    tick_a(3'b000, 3'b000, 1'b0, "rt_drop_off");
    tick_a(3'b000, 3'b000, 1'b0, "rt_drop_idle");

    // lt -> rt switch mid-sequence
    lt_a = 1'b1;
    tick_a(3'b001, 3'b000, 1'b1, "sw_l1");
    lt_a = 1'b0;
    rt_a = 1'b1;
    tick_a(3'b011, 3'b000, 1'b1, "sw_l2");
    tick_a(3'b111, 3'b000, 1'b1, "sw_l3");
    tick_a(3'b000, 3'b000, 1'b0, "sw_off");
    tick_a(3'b000, 3'b001, 1'b1, "sw_r1");
    rt_a = 1'b0;
    tick_a(3'b000, 3'b011, 1'b1, "sw_r2");
    tick_a(3'b000, 3'b111, 1'b1, "sw_r3");
    tick_a(3'b000, 3'b000, 1'b0, "sw_r_off");

    // hazard preempts a left sequence at step 2
    lt_a = 1'b1;
    tick_a(3'b001, 3'b000, 1'b1, "hz_l1");
    tick_a(3'b011, 3'b000, 1'b1, "hz_l2");
    haz_a = 1'b1;
    tick_a(3'b111, 3'b111, 1'b1, "hz_on1");
    tick_a(3'b000, 3'b000, 1'b1, "hz_off1");
    tick_a(3'b111, 3'b111, 1'b1, "hz_on2");
    haz_a = 1'b0;
    lt_a  = 1'b0;
    tick_a(3'b000, 3'b000, 1'b0, "hz_drop");

    // lt & rt together behaves as hazard
    lt_a = 1'b1;
    rt_a = 1'b1;
    tick_a(3'b111, 3'b111, 1'b1, "lr_on1");
    tick_a(3'b000, 3'b000, 1'b1, "lr_off1");
    tick_a(3'b111, 3'b111, 1'b1, "lr_on2");
    lt_a = 1'b0;
    rt_a = 1'b0;
    tick_a(3'b000, 3'b000, 1'b0, "lr_drop");

`ifdef TL_BRAKE_EN
    // brake acts on the next edge, independent of the tick
    brk_a = 1'b1;
    step_a(1, 3'b111, 3'b111, 1'b0, "brk_idle_on");
    brk_a = 1'b0;
    step_a(1, 3'b000, 3'b000, 1'b0, "brk_idle_off");
    step_a(2, 3'b000, 3'b000, 1'b0, "brk_realign");
    lt_a  = 1'b1;
    brk_a = 1'b1;
    tick_a(3'b001, 3'b111, 1'b1, "brk_lt_s1");
    tick_a(3'b011, 3'b111, 1'b1, "brk_lt_s2");
    tick_a(3'b111, 3'b111, 1'b1, "brk_lt_s3");
    lt_a  = 1'b0;
    tick_a(3'b111, 3'b111, 1'b0, "brk_lt_idle");
    haz_a = 1'b1;
    tick_a(3'b111, 3'b111, 1'b1, "brk_haz_on");
    tick_a(3'b000, 3'b000, 1'b1, "brk_haz_off");
    haz_a = 1'b0;
    brk_a = 1'b0;
    tick_a(3'b000, 3'b000, 1'b0, "brk_end");
`endif

    // LAMPS=5, DIV=1: one step per clk
    lt5 = 1'b1;
    @(negedge clk);
    rst5 = 1'b0;
    begin
      logic [4:0] p5 [7];
      p5[0] = 5'b00001; p5[1] = 5'b00011; p5[2] = 5'b00111; p5[3] = 5'b01111;
      p5[4] = 5'b11111; p5[5] = 5'b00000; p5[6] = 5'b00001;
      for (int k = 0; k < 7; k++) begin
        push(p5[k], 5'd0, k != 5);
        edges(1);
        check_pop($sformatf("l5_div1_e%0d", k + 1), {li5, ri5, busy5});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
